// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready command front end that sequences a single-port synchronous RAM over a tri-state bus.
module ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_w_r1,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;
  logic [2:0]            state, nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  always_comb begin
    nxt = state == IDLE    ? (req_valid ? (req_write ? WRITE : RD_ADDR) : IDLE) :
          state == RD_ADDR ? RD_DATA :
          state == RD_DATA ? RESP :
          state == RESP    ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= nxt;
      if (req_valid && req_ready) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == RD_DATA) rdata_q <= ram_data;
    end
  end
  // All strobes decode from state only, so the async reset drops ram_cs immediately.
  assign req_ready   = state == IDLE;
  assign rsp_valid   = state == RESP;
  assign rsp_rdata   = rdata_q;
  assign ram_cs      = state == WRITE || state == RD_ADDR || state == RD_DATA;
  assign ram_w_r1    = state == WRITE;
  assign ram_oe      = state == RD_DATA;
  assign ram_address = addr_q;
  assign ram_data    = ram_w_r1 ? wdata_q : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed and random checks of ram_ctrl against a behavioural RAM and a scoreboard.
module tb_ram_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [7:0] req_addr = '0, req_wdata = '0;
  wire req_ready, rsp_valid, ram_cs, ram_w_r1, ram_oe;
  wire [7:0] rsp_rdata, ram_address;
  wire [7:0] ram_data;
  logic [7:0] mem [256];
  logic [7:0] sb [256];
  logic [7:0] ram_q = '0;
  int accesses = 0, vectors = 0, miscompares = 0;
  bit mon_en = 1'b0;
  always #5 clk = ~clk;
  ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_w_r1(ram_w_r1), .ram_oe(ram_oe),
    .ram_address(ram_address), .ram_data(ram_data)
  );
  // Behavioural RAM obeying the contract: registered read, bus driven only with cs && !w_r1 && oe.
  assign ram_data = (ram_cs && !ram_w_r1 && ram_oe) ? ram_q : 8'bz;
  always @(posedge clk) begin
    if (ram_cs) begin
      accesses++;
      if (ram_w_r1) mem[ram_address] <= ram_data;
      else ram_q <= mem[ram_address];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_cs && (ram_w_r1 || ram_oe)) chk("bus_no_x", 32'($isunknown(ram_data)), 0);
      if (ram_oe) chk("no_drive_during_oe", 32'(ram_w_r1), 0);
      if (!ram_cs) chk("bus_released", 32'(ram_data === 8'bz), 1);
    end
  end
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    sb[a] = d;
    @(negedge clk);
  endtask
  task automatic rd(input logic [7:0] a, input string tag);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(rsp_valid), 1);
    chk(tag, 32'(rsp_rdata), 32'(sb[a]));
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      sb[i] = '0;
    end
    // Reset held 3 cycles with a pending command
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h42; req_wdata = 8'h99;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_cs", 32'(ram_cs), 0);
    chk("rst_w_r1", 32'(ram_w_r1), 0);
    chk("rst_oe", 32'(ram_oe), 0);
    chk("rst_addr", 32'(ram_address), 0);
    chk("rst_bus_z", 32'(ram_data === 8'bz), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_no_access", 32'(accesses), 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_cs", 32'(ram_cs), 0);
    // Write 0x3C to 0x10: one-cycle write strobe
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    sb[8'h10] = 8'h3C;
    chk("wr_cs", 32'(ram_cs), 1);
    chk("wr_w_r1", 32'(ram_w_r1), 1);
    chk("wr_oe", 32'(ram_oe), 0);
    chk("wr_addr", 32'(ram_address), 32'h10);
    chk("wr_bus", 32'(ram_data), 32'h3C);
    chk("wr_not_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("wr_cs_done", 32'(ram_cs), 0);
    chk("wr_ready_again", 32'(req_ready), 1);
    chk("wr_mem", 32'(mem[8'h10]), 32'h3C);
    // Read 0x10 with cycle-exact latency
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_addr_cs", 32'(ram_cs), 1);
    chk("rd_addr_oe", 32'(ram_oe), 0);
    chk("rd_e1_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("rd_data_oe", 32'(ram_oe), 1);
    chk("rd_data_bus", 32'(ram_data), 32'h3C);
    chk("rd_e2m_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("rd_e2_valid", 32'(rsp_valid), 1);
    chk("rd_rdata", 32'(rsp_rdata), 32'h3C);
    chk("rd_resp_cs", 32'(ram_cs), 0);
    @(negedge clk);
    chk("rd_ready_again", 32'(req_ready), 1);
    chk("rd_valid_clear", 32'(rsp_valid), 0);
    // Boundary addresses
    wr(8'h00, 8'hA5);
    wr(8'hFF, 8'h5A);
    rd(8'h00, "rd_00");
    rd(8'hFF, "rd_ff");
    chk("addr_hold_idle", 32'(ram_address), 32'hFF);
    chk("rdata_hold_after_wr", 32'(rsp_rdata), 32'h5A);
    // Response backpressure
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_rdata", 32'(rsp_rdata), 32'h3C);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_cs", 32'(ram_cs), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release_ready", 32'(req_ready), 1);
    chk("bp_release_valid", 32'(rsp_valid), 0);
    rsp_ready = 1'b1;
    // Reset during WRITE must suppress the RAM write
    wr(8'h20, 8'h77);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h11;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midwr_cs_before", 32'(ram_cs), 1);
    rst_n = 1'b0;
    #1;
    chk("midwr_cs_dropped", 32'(ram_cs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(8'h20, "midwr_readback");
    // Random traffic with bus monitor
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) wr(8'($urandom_range(0, 255)), 8'($urandom));
      else rd(8'($urandom_range(0, 255)), "rand_rd");
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
